// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and access-legality helper for the
// data-memory responder.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int RSP_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Alignment and funct3 legality; range is checked by the caller.
    function automatic logic access_err(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (funct3)
            F3_B, F3_BU: bad = we && (funct3 == F3_BU);
            F3_H, F3_HU: bad = (we && (funct3 == F3_HU)) || lane[0];
            F3_W:        bad = (lane != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half of a memory word and applies RV32I
// sign or zero extension.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection then extension by funct3.
    always_comb begin
        byte_s = word[8*lane +: 8];
        half_s = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
            F3_BU:   rdata = {24'h000000, byte_s};
            F3_H:    rdata = {{16{half_s[15]}}, half_s};
            F3_HU:   rdata = {16'h0000, half_s};
            F3_W:    rdata = word;
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory load/store interface: one
// transaction at a time, fixed LATENCY from accept to response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RSP_DATA_W-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic            we_r;
    logic [2:0]      f3_r;
    logic [31:0]     addr_r;
    logic [31:0]     wdata_r;
    logic [31:0]     mem_r [DEPTH_WORDS];

    logic            rsp_valid_r;
    logic            rsp_err_r;
    logic [31:0]     rsp_rdata_r;

    logic            accept_s;
    logic            access_s;
    logic            range_err_s;
    logic            err_s;
    logic [AW-1:0]   idx_s;
    logic [31:0]     word_s;
    logic [31:0]     load_s;
    logic [3:0]      be_s;
    logic [31:0]     wlanes_s;
    logic [31:0]     merged_s;

    assign accept_s    = req_valid && (state_r == ST_IDLE);
    assign access_s    = (state_r == ST_BUSY) && (cnt_r == 4'd0);
    assign idx_s       = addr_r[AW+1:2];
    assign range_err_s = ({2'b00, addr_r[31:2]} >= 32'(DEPTH_WORDS));
    assign err_s       = range_err_s || access_err(we_r, f3_r, addr_r[1:0]);
    assign word_s      = mem_r[idx_s];

    // Ready is withheld while reset is asserted even though state reads IDLE.
    assign req_ready = (state_r == ST_IDLE) && !rst;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    load_extend u_load_extend (
        .word   (word_s),
        .lane   (addr_r[1:0]),
        .funct3 (f3_r),
        .rdata  (load_s)
    );

    // Store byte enables and lane-replicated write data merged into the old word.
    always_comb begin
        case (f3_r)
            F3_B: begin
                be_s     = 4'b0001 << addr_r[1:0];
                wlanes_s = {4{wdata_r[7:0]}};
            end
            F3_H: begin
                be_s     = addr_r[1] ? 4'b1100 : 4'b0011;
                wlanes_s = {2{wdata_r[15:0]}};
            end
            F3_W: begin
                be_s     = 4'b1111;
                wlanes_s = wdata_r;
            end
            default: begin
                be_s     = 4'b0000;
                wlanes_s = 32'h0000_0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            merged_s[8*i +: 8] = be_s[i] ? wlanes_s[8*i +: 8] : word_s[8*i +: 8];
        end
    end

    // Next-state and latency counter.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_BUSY;
                    cnt_s   = LAT_M1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request fields are captured only on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r    <= 1'b0;
            f3_r    <= 3'b000;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r    <= req_we;
            f3_r    <= req_funct3;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end else begin
            we_r    <= we_r;
            f3_r    <= f3_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Response registers: loaded on the access edge, cleared on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else if (access_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= err_s;
            rsp_rdata_r <= (err_s || we_r) ? 32'h0000_0000 : load_s;
        end else if ((state_r == ST_RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= rsp_valid_r;
            rsp_err_r   <= rsp_err_r;
            rsp_rdata_r <= rsp_rdata_r;
        end
    end

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (access_s && we_r && !err_s) begin
            mem_r[idx_s] <= merged_s;
        end
    end

endmodule
